serial_dft_bin_engine: RTL and testbench
========================================

Name: serial_dft_bin_engine

Overview:
- Multi-channel serial single-bin DFT accumulator: one real sample per channel per accepted beat, multiplied by an externally supplied twiddle (w_re, w_im) addressed by the block's own sample index.
- Each channel accumulates re/im over FRAME_LENGTH samples. The completed bin is moved into an output register and held under a valid/ready handshake, so the accumulator restarts without waiting for the consumer.
- Sits between the sample front-end and the spectral post-processing. The twiddle ROM is external and driven by sample_idx.

Parameters:
- W_WIDTH, 16, signed twiddle component width.
- X_WIDTH, 16, signed input sample width per channel.
- S_WIDTH, 40, signed accumulator and output width; must be at least W_WIDTH+X_WIDTH.
- FRAME_LENGTH, 8, samples per frame; must be at least 2.
- CHANNELS, 4, independent channels sharing the twiddle and handshake.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous reset, active-low.
- clear  in  1  synchronous frame abort.
- sample_idx  out  $clog2(FRAME_LENGTH)  index of the next sample to be accepted; drives the twiddle ROM address.
- w_re  in  W_WIDTH  signed twiddle real part for sample_idx, valid in the same cycle.
- w_im  in  W_WIDTH  signed twiddle imaginary part for sample_idx, valid in the same cycle.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- x  in  CHANNELS*X_WIDTH  packed signed samples; channel c occupies bits [c*X_WIDTH +: X_WIDTH].
- in_last  out  1  combinational; high when the accepted beat is sample FRAME_LENGTH-1.
- out_valid  out  1  frame result held in the output register.
- out_ready  in  1  consumer accepts the result.
- re  out  CHANNELS*S_WIDTH  packed signed real bin, one S_WIDTH field per channel.
- im  out  CHANNELS*S_WIDTH  packed signed imaginary bin, one S_WIDTH field per channel.
- frame_cnt  out  16  count of completed frames; wraps modulo 2^16.

Behaviour:
- Reset (rstn=0 at a clk edge) forces:
  - sample_idx=0;
  - all accumulators=0;
  - re=0, im=0;
  - out_valid=0;
  - frame_cnt=0.
  - Reset applied mid-frame discards the partial frame and any unconsumed result.
- Accept: acc = in_valid && in_ready.
- in_ready = !(sample_idx==FRAME_LENGTH-1 && out_valid && !out_ready).
  - Stalls only on the last beat, and only while the previous result is still unconsumed.
  - It is combinational from out_ready.
- in_last = acc && (sample_idx==FRAME_LENGTH-1).
- Products, per channel c:
  - pr = x[c]*w_re and pi = x[c]*w_im, each signed W_WIDTH+X_WIDTH bits.
  - Each product is sign-extended to S_WIDTH.
- Accumulator update on acc:
  - If sample_idx==0: acc_re = pr and acc_im = pi. The old value is overwritten; no separate clear cycle is needed.
  - Otherwise: acc_re += pr and acc_im += pi.
  - Addition wraps modulo 2^S_WIDTH, unless the optional feature is enabled.
- sample_idx on acc:
  - Increments by 1.
  - Wraps to 0 after FRAME_LENGTH-1.
  - Holds when there is no acc.
- Frame completion (in_last):
  - On that edge, re and im load the final sums (accumulator plus the last product).
  - out_valid goes to 1 and frame_cnt increments.
  - Latency: the result is visible 1 cycle after the last sample is accepted.
- Output handshake:
  - out_valid && out_ready with no simultaneous in_last: out_valid goes to 0 next cycle; re/im hold their stale values.
  - Simultaneous consume and in_last: the new result loads and out_valid stays 1.
  - re/im are stable while out_valid=1 and out_ready=0.
- clear: sample_idx goes to 0 and the partial frame is discarded.
  - out_valid, re, im and frame_cnt are unaffected.
  - clear has priority over a same-cycle accept: the beat is dropped and in_last is suppressed.
- Non-power-of-2 FRAME_LENGTH: sample_idx never exceeds FRAME_LENGTH-1.

Optional Feature:
- Macro: SERIAL_DFT_BIN_SAT_EN.
- Defined: each accumulator add saturates to the signed S_WIDTH range.
  - Overflow clamps to 2^(S_WIDTH-1)-1 or -2^(S_WIDTH-1).
  - A sticky output port sat_flag, CHANNELS bits, sets per channel on any saturation within the frame.
  - sat_flag is registered with re/im at frame completion; reset value 0.
- Undefined: wrapping add, and no sat_flag port.

Test Plan (FRAME_LENGTH=4, CHANNELS=2, W_WIDTH=X_WIDTH=16, S_WIDTH=40 unless stated):
- Basic sum: w=(1,0) every beat; ch0 x=1,2,3,4; ch1 x=-5 four times; out_ready=1.
  - Expect re0=10, re1=-20, im=0.
  - out_valid high exactly 1 cycle after the 4th beat; frame_cnt=1.
- Twiddle index: ROM returns w_re=sample_idx+1, w_im=-(sample_idx); ch0 x=2 on all beats.
  - Expect re0=20, im0=-12.
  - sample_idx sequence 0,1,2,3,0.
- Backpressure: out_ready=0, two full frames offered back to back.
  - Frame 1 held; in_ready drops at sample_idx=3 of frame 2.
  - Raising out_ready: frame 2's last beat is accepted the same cycle, out_valid stays 1, and re switches to frame 2's value.
- clear: clear asserted at sample_idx=2, then a fresh 4-beat frame of x=1, w=(1,0).
  - Expect re0=4 with no contribution from the aborted beats; the earlier result is untouched.
- Reset mid-frame: rstn=0 for 1 cycle after 2 beats, with out_valid=1 from an earlier frame.
  - All outputs 0 and sample_idx=0 next cycle; the next frame sums correctly.
- Wrap vs saturation: S_WIDTH=32, x=-32768, w_re=-32768, over 4 beats.
  - Without SERIAL_DFT_BIN_SAT_EN: re0=0 (modulo 2^32).
  - With it: re0=2147483647 and sat_flag[0]=1.

Source files
------------

// File: rtl/serial_dft_bin_engine.sv
// Multi-channel serial single-bin DFT accumulator with a held, handshaked result register.
// Define SERIAL_DFT_BIN_SAT_EN for saturating accumulation and a per-channel sat_flag output.
module serial_dft_bin_engine #(
  parameter int W_WIDTH      = 16,
  parameter int X_WIDTH      = 16,
  parameter int S_WIDTH      = 40,
  parameter int FRAME_LENGTH = 8,
  parameter int CHANNELS     = 4
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               clear,
  output logic [$clog2(FRAME_LENGTH)-1:0]    sample_idx,
  input  logic [W_WIDTH-1:0]                 w_re,
  input  logic [W_WIDTH-1:0]                 w_im,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [CHANNELS*X_WIDTH-1:0]        x,
  output logic                               in_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [CHANNELS*S_WIDTH-1:0]        re,
  output logic [CHANNELS*S_WIDTH-1:0]        im,
  output logic [15:0]                        frame_cnt
`ifdef SERIAL_DFT_BIN_SAT_EN
  ,
  output logic [CHANNELS-1:0]                sat_flag
`endif
);

  localparam int IW      = $clog2(FRAME_LENGTH);
  localparam int P_WIDTH = W_WIDTH + X_WIDTH;
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LENGTH - 1);

  logic [IW-1:0]              sample_idx_q, sample_idx_d;
  logic signed [S_WIDTH-1:0]  acc_re_q [CHANNELS];
  logic signed [S_WIDTH-1:0]  acc_re_d [CHANNELS];
  logic signed [S_WIDTH-1:0]  acc_im_q [CHANNELS];
  logic signed [S_WIDTH-1:0]  acc_im_d [CHANNELS];
  logic [CHANNELS*S_WIDTH-1:0] re_q, re_d, im_q, im_d;
  logic                       out_valid_q, out_valid_d;
  logic [15:0]                frame_cnt_q, frame_cnt_d;
  logic                       is_last, take, done;

`ifdef SERIAL_DFT_BIN_SAT_EN
  localparam logic signed [S_WIDTH-1:0] S_MAX = {1'b0, {(S_WIDTH-1){1'b1}}};
  localparam logic signed [S_WIDTH-1:0] S_MIN = {1'b1, {(S_WIDTH-1){1'b0}}};

  logic [CHANNELS-1:0] sat_acc_q, sat_acc_d, sat_flag_q, sat_flag_d;

  // Overflow only when both addends share a sign and the sum's sign differs.
  function automatic logic signed [S_WIDTH-1:0] add_sat(
    input  logic signed [S_WIDTH-1:0] a,
    input  logic signed [S_WIDTH-1:0] b,
    output logic                      ovf
  );
    logic signed [S_WIDTH-1:0] s;
    s   = a + b;
    ovf = (a[S_WIDTH-1] == b[S_WIDTH-1]) && (s[S_WIDTH-1] != a[S_WIDTH-1]);
    if (ovf) s = a[S_WIDTH-1] ? S_MIN : S_MAX;
    return s;
  endfunction
`endif

  // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
  always_comb begin : comb_p
    logic signed [P_WIDTH-1:0] pr, pi;
    logic signed [S_WIDTH-1:0] base_re, base_im, sum_re, sum_im;
`ifdef SERIAL_DFT_BIN_SAT_EN
    logic ovf_re, ovf_im;
    sat_acc_d  = sat_acc_q;
    sat_flag_d = sat_flag_q;
`endif
    is_last  = (sample_idx_q == LAST_IDX);
    in_ready = !(is_last && out_valid_q && !out_ready);
    take     = in_valid && in_ready && !clear;
    done     = take && is_last;

    re_d = re_q;
    im_d = im_q;
    for (int c = 0; c < CHANNELS; c++) begin
      acc_re_d[c] = acc_re_q[c];
      acc_im_d[c] = acc_im_q[c];
      pr = P_WIDTH'($signed(x[c*X_WIDTH +: X_WIDTH])) * P_WIDTH'($signed(w_re));
      pi = P_WIDTH'($signed(x[c*X_WIDTH +: X_WIDTH])) * P_WIDTH'($signed(w_im));
      // Index 0 starts a new frame by overwriting instead of adding.
      base_re = (sample_idx_q == '0) ? '0 : acc_re_q[c];
      base_im = (sample_idx_q == '0) ? '0 : acc_im_q[c];
`ifdef SERIAL_DFT_BIN_SAT_EN
      sum_re = add_sat(base_re, S_WIDTH'(pr), ovf_re);
      sum_im = add_sat(base_im, S_WIDTH'(pi), ovf_im);
      if (take) begin
        sat_acc_d[c] = ((sample_idx_q == '0) ? 1'b0 : sat_acc_q[c]) | ovf_re | ovf_im;
      end
      if (done) sat_flag_d[c] = sat_acc_d[c];
`else
      sum_re = base_re + S_WIDTH'(pr);
      sum_im = base_im + S_WIDTH'(pi);
`endif
      if (take) begin
        acc_re_d[c] = sum_re;
        acc_im_d[c] = sum_im;
      end
      if (done) begin
        re_d[c*S_WIDTH +: S_WIDTH] = sum_re;
        im_d[c*S_WIDTH +: S_WIDTH] = sum_im;
      end
    end

    sample_idx_d = sample_idx_q;
    if (clear)     sample_idx_d = '0;
    else if (take) sample_idx_d = is_last ? '0 : sample_idx_q + IW'(1);

    out_valid_d = out_valid_q;
    if (done)                           out_valid_d = 1'b1;
    else if (out_valid_q && out_ready)  out_valid_d = 1'b0;

    frame_cnt_d = frame_cnt_q + {15'd0, done};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sample_idx_q <= '0;
      re_q         <= '0;
      im_q         <= '0;
      out_valid_q  <= 1'b0;
      frame_cnt_q  <= '0;
      // NOTE: the accumulator array is reset too, so no stale partial sum survives a reset.
      for (int c = 0; c < CHANNELS; c++) begin
        acc_re_q[c] <= '0;
        acc_im_q[c] <= '0;
      end
`ifdef SERIAL_DFT_BIN_SAT_EN
      sat_acc_q  <= '0;
      sat_flag_q <= '0;
`endif
    end else begin
      sample_idx_q <= sample_idx_d;
      re_q         <= re_d;
      im_q         <= im_d;
      out_valid_q  <= out_valid_d;
      frame_cnt_q  <= frame_cnt_d;
      for (int c = 0; c < CHANNELS; c++) begin
        acc_re_q[c] <= acc_re_d[c];
        acc_im_q[c] <= acc_im_d[c];
      end
`ifdef SERIAL_DFT_BIN_SAT_EN
      sat_acc_q  <= sat_acc_d;
      sat_flag_q <= sat_flag_d;
`endif
    end
  end

  assign sample_idx = sample_idx_q;
  assign in_last    = done;
  assign out_valid  = out_valid_q;
  assign re         = re_q;
  assign im         = im_q;
  assign frame_cnt  = frame_cnt_q;
`ifdef SERIAL_DFT_BIN_SAT_EN
  assign sat_flag   = sat_flag_q;
`endif

endmodule

// File: tb/tb_serial_dft_bin_engine.sv
// Bench for serial_dft_bin_engine: frame-level reference model checked every cycle,
// plus directed scenarios with hand-computed results.
module tb_serial_dft_bin_engine;
  localparam int FL   = 4;
  localparam int CH   = 2;
  localparam int XW   = 16;
  localparam int WW   = 16;
  localparam int SW   = 40;
  localparam int SW32 = 32;
  localparam int IW   = 2;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b1;
  logic              rom_mode = 1'b0;
  logic [IW-1:0]     sample_idx;
  logic [WW-1:0]     w_re, w_im;
  logic [WW-1:0]     w_re_drv = '0, w_im_drv = '0;
  logic              in_ready, in_last, out_valid;
  logic [CH*XW-1:0]  x = '0;
  logic [CH*SW-1:0]  re, im;
  logic [15:0]       frame_cnt;

  logic              in_valid32 = 1'b0;
  logic [CH*XW-1:0]  x32 = '0;
  logic [WW-1:0]     w_re32 = '0, w_im32 = '0;
  logic [IW-1:0]     sample_idx32;
  logic              in_ready32, in_last32, out_valid32;
  logic [CH*SW32-1:0] re32, im32;
  logic [15:0]       frame_cnt32;
`ifdef SERIAL_DFT_BIN_SAT_EN
  logic [CH-1:0]     sat_flag, sat_flag32;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Twiddle ROM: a fixed test pattern, or the index-driven pattern.
  assign w_re = rom_mode ? WW'(sample_idx) + WW'(1) : w_re_drv;
  assign w_im = rom_mode ? WW'(0) - WW'(sample_idx) : w_im_drv;

  serial_dft_bin_engine #(.W_WIDTH(WW), .X_WIDTH(XW), .S_WIDTH(SW),
                          .FRAME_LENGTH(FL), .CHANNELS(CH)) dut (
    .clk(clk), .rstn(rstn), .clear(clear), .sample_idx(sample_idx),
    .w_re(w_re), .w_im(w_im), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .re(re), .im(im), .frame_cnt(frame_cnt)
`ifdef SERIAL_DFT_BIN_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  serial_dft_bin_engine #(.W_WIDTH(WW), .X_WIDTH(XW), .S_WIDTH(SW32),
                          .FRAME_LENGTH(FL), .CHANNELS(CH)) dut32 (
    .clk(clk), .rstn(rstn), .clear(1'b0), .sample_idx(sample_idx32),
    .w_re(w_re32), .w_im(w_im32), .in_valid(in_valid32), .in_ready(in_ready32),
    .x(x32), .in_last(in_last32), .out_valid(out_valid32), .out_ready(1'b1),
    .re(re32), .im(im32), .frame_cnt(frame_cnt32)
`ifdef SERIAL_DFT_BIN_SAT_EN
    , .sat_flag(sat_flag32)
`endif
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint fld(input logic [CH*SW-1:0] v, input int c);
    return longint'($signed(v[c*SW +: SW]));
  endfunction

  function automatic longint fld32(input logic [CH*SW32-1:0] v, input int c);
    return longint'($signed(v[c*SW32 +: SW32]));
  endfunction

  function automatic longint wrap_sw(input longint v);
    return (v <<< (64 - SW)) >>> (64 - SW);
  endfunction

  // Reference model: frames as lists of accepted beats, summed when a frame completes.
  bit               m_on = 1'b0;
  int               m_idx, m_fc;
  bit               m_ov;
  longint           m_re [CH];
  longint           m_im [CH];
  logic [CH*XW-1:0] q_x [$];
  logic [WW-1:0]    q_wr [$];
  logic [WW-1:0]    q_wi [$];

  always @(negedge clk) begin
    bit exp_rdy, m_take;
    longint s_re, s_im;
    if (!rstn) begin
      m_on = 1'b1; m_idx = 0; m_ov = 1'b0; m_fc = 0;
      for (int c = 0; c < CH; c++) begin m_re[c] = 0; m_im[c] = 0; end
      q_x.delete(); q_wr.delete(); q_wi.delete();
    end else if (m_on) begin
      exp_rdy = !(m_idx == FL-1 && m_ov && !out_ready);
      m_take  = in_valid && exp_rdy && !clear;
      check("m_in_ready", in_ready, exp_rdy);
      check("m_in_last", in_last, m_take && m_idx == FL-1);
      check("m_sample_idx", sample_idx, m_idx);
      check("m_out_valid", out_valid, m_ov);
      check("m_frame_cnt", frame_cnt, m_fc);
      for (int c = 0; c < CH; c++) begin
        check("m_re", fld(re, c), m_re[c]);
        check("m_im", fld(im, c), m_im[c]);
      end
`ifdef SERIAL_DFT_BIN_SAT_EN
      check("m_sat_flag", sat_flag, 0);
`endif
      if (m_ov && out_ready) m_ov = 1'b0;
      if (clear) begin
        q_x.delete(); q_wr.delete(); q_wi.delete();
        m_idx = 0;
      end else if (m_take) begin
        q_x.push_back(x); q_wr.push_back(w_re); q_wi.push_back(w_im);
        if (m_idx == FL-1) begin
          for (int c = 0; c < CH; c++) begin
            s_re = 0; s_im = 0;
            for (int k = 0; k < q_x.size(); k++) begin
              s_re += longint'($signed(q_x[k][c*XW +: XW])) * longint'($signed(q_wr[k]));
              s_im += longint'($signed(q_x[k][c*XW +: XW])) * longint'($signed(q_wi[k]));
            end
            m_re[c] = wrap_sw(s_re);
            m_im[c] = wrap_sw(s_im);
          end
          m_ov  = 1'b1;
          m_fc  = (m_fc + 1) % 65536;
          m_idx = 0;
          q_x.delete(); q_wr.delete(); q_wi.delete();
        end else begin
          m_idx++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and hold it until accepted, within a bounded number of cycles.
  task automatic send(input int x0, input int x1, input int wr, input int wi);
    in_valid = 1'b1;
    x        = {XW'(x1), XW'(x0)};
    w_re_drv = WW'(wr);
    w_im_drv = WW'(wi);
    for (int i = 0; i < 20; i++) begin
      if (in_ready && !clear) begin
        step();
        in_valid = 1'b0;
        return;
      end
      step();
    end
    n_checks++;
    n_fail++;
    $display("FAIL send_timeout: beat not accepted within 20 cycles at %0t", $time);
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    rstn = 1'b1;
    check("reset_idx", sample_idx, 0);
    check("reset_valid", out_valid, 0);
    check("reset_cnt", frame_cnt, 0);
    check("reset_re0", fld(re, 0), 0);

    // Basic sum
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(k + 1, -5, 1, 0);
      if (k == 2) check("basic_valid_early", out_valid, 0);
    end
    check("basic_valid", out_valid, 1);
    check("basic_re0", fld(re, 0), 10);
    check("basic_re1", fld(re, 1), -20);
    check("basic_im0", fld(im, 0), 0);
    check("basic_im1", fld(im, 1), 0);
    check("basic_cnt", frame_cnt, 1);
    step();
    check("basic_consumed", out_valid, 0);

    // Twiddle index drives the ROM
    rom_mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("twiddle_idx", sample_idx, k);
      send(2, 0, 0, 0);
    end
    check("twiddle_idx_wrap", sample_idx, 0);
    check("twiddle_re0", fld(re, 0), 20);
    check("twiddle_im0", fld(im, 0), -12);
    rom_mode = 1'b0;
    step();

    // Backpressure: two frames back to back with the consumer stalled
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(1, 2, 1, 0);
    check("bp_a_valid", out_valid, 1);
    check("bp_a_re0", fld(re, 0), 4);
    check("bp_a_re1", fld(re, 1), 8);
    for (int k = 0; k < 3; k++) send(3, -1, 1, 0);
    in_valid = 1'b1;
    #1;
    check("bp_stall_ready", in_ready, 0);
    check("bp_stall_idx", sample_idx, 3);
    step(); step();
    check("bp_hold_re0", fld(re, 0), 4);
    check("bp_hold_ready", in_ready, 0);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("bp_b_valid", out_valid, 1);
    check("bp_b_re0", fld(re, 0), 12);
    check("bp_b_re1", fld(re, 1), -4);
    check("bp_b_cnt", frame_cnt, 4);

    // clear aborts the partial frame, result register untouched
    send(7, 7, 1, 0);
    send(7, 7, 1, 0);
    in_valid = 1'b1;
    clear    = 1'b1;
    #1;
    check("clear_in_last", in_last, 0);
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear_idx", sample_idx, 0);
    check("clear_valid", out_valid, 1);
    check("clear_re0", fld(re, 0), 12);
    check("clear_cnt", frame_cnt, 4);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) send(1, 0, 1, 0);
    check("clear_fresh_re0", fld(re, 0), 4);
    check("clear_fresh_cnt", frame_cnt, 5);

    // Reset mid-frame with a result still held
    out_ready = 1'b0;
    send(5, 0, 1, 0);
    send(5, 0, 1, 0);
    check("rst_pre_valid", out_valid, 1);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    check("rst_valid", out_valid, 0);
    check("rst_idx", sample_idx, 0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_re0", fld(re, 0), 0);
    check("rst_im0", fld(im, 0), 0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) send(k + 1, 0, 1, 0);
    check("rst_next_re0", fld(re, 0), 10);
    check("rst_next_cnt", frame_cnt, 1);

    // Wrap versus saturation on the 32-bit instance
    in_valid32 = 1'b1;
    x32        = {16'd0, 16'h8000};
    w_re32     = 16'h8000;
    w_im32     = 16'd0;
    repeat (4) step();
    in_valid32 = 1'b0;
    check("w32_valid", out_valid32, 1);
    check("w32_cnt", frame_cnt32, 1);
    check("w32_im0", fld32(im32, 0), 0);
`ifdef SERIAL_DFT_BIN_SAT_EN
    check("w32_re0_sat", fld32(re32, 0), 2147483647);
    check("w32_sat_flag0", sat_flag32[0], 1);
    check("w32_sat_flag1", sat_flag32[1], 0);
`else
    check("w32_re0_wrap", fld32(re32, 0), 0);
`endif
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
